spm_dual_port: RTL and testbench
================================

Name: spm_dual_port

Overview:
- True dual-port scratchpad memory (SPM): 4096 words × 32 bits.
- Port IF serves instruction fetch; port MEM serves the load/store stage.
- Both ports are fully symmetric. Each has an independent address strobe, a read/write select and a write-data bus, and each has its own registered read-data output.
- Sits beside the pipeline as tightly coupled local memory.

Parameters:
- ADDR_W, 12, word-address width.
- DATA_W, 32, word width.
- DEPTH, 4096, number of words (2**ADDR_W).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_  input  1  reset, asynchronous, active-low.
- if_spm_addr  input  12  IF-port word address.
- if_spm_as_  input  1  IF-port address strobe, active-low; 0 = access this cycle.
- if_spm_rw  input  1  IF-port direction; 1 = READ, 0 = WRITE.
- if_spm_wr_data  input  32  IF-port write data.
- mem_spm_addr  input  12  MEM-port word address.
- mem_spm_as_  input  1  MEM-port address strobe, active-low.
- mem_spm_rw  input  1  MEM-port direction; 1 = READ, 0 = WRITE.
- mem_spm_wr_data  input  32  MEM-port write data.
- if_spm_rd_data  output  32  IF-port read data (registered).
- mem_spm_rd_data  output  32  MEM-port read data (registered).

Behaviour:
- Reset:
  - While rst_ = 0, both rd_data outputs are forced to 0 asynchronously and stay 0 until the first read after rst_ rises.
  - Array contents are not reset. Locations never written read as undefined.
- Addressing: addresses are word indices 0..4095, with no byte lanes and no alignment check. All 12 bits are decoded, so no wrap or alias occurs.
- Write: at a rising edge with as_ = 0 and rw = 0, mem[addr] <= wr_data. The port's rd_data holds its previous value.
- Read:
  - At a rising edge with as_ = 0 and rw = 1, rd_data <= mem[addr].
  - Latency is one cycle: data appears after the edge that samples the address.
  - A new read can be issued every cycle (full throughput).
- Idle: when as_ = 1, no array access occurs, rw/addr/wr_data are ignored (X tolerated), and rd_data holds its value.
- Read-during-write:
  - Read-first policy. A read of address A in the same cycle that either port writes A returns the old contents of A.
  - The new value is visible to reads issued from the next cycle onward.
- Write collision: when both ports write the same address in the same edge, the MEM-port data is stored and the IF-port write is discarded. Different addresses are written independently.
- Simultaneous reads: both ports may read any addresses concurrently, including the same address, with no stall.
- Reset mid-operation:
  - An access sampled at the same edge as rst_ falling is abandoned.
  - A write in flight may or may not land; software must not rely on it.
  - Outputs go to 0 immediately.
- No handshake or ready signal. The block never back-pressures.

Test Plan:
- Sequential fill via MEM port: write mem[i] = i for i = 0..39 on consecutive cycles, IF port idle (as_ = 1). Then read i = 0..39 → mem_spm_rd_data equals i one cycle after each address is sampled; if_spm_rd_data stays 0.
- IF-port readback: after the fill, IF reads addr 5, 39, 0 → if_spm_rd_data = 5, 39, 0 with one-cycle latency. Concurrently MEM reads addr 7 → 7.
- Write collision: both ports write addr 100 in the same cycle, IF data 0xAAAA_AAAA and MEM data 0x5555_5555 → a subsequent read returns 0x5555_5555.
- Read-during-write: mem[200] = 0x1234; in one cycle MEM writes 0xBEEF to 200 while IF reads 200 → if_spm_rd_data = 0x1234. A read the next cycle → 0xBEEF.
- Hold/idle: after a read returning 0x1234, deassert as_ (or issue writes) for 5 cycles → rd_data remains 0x1234.
- Reset: mid-stream reads, assert rst_ = 0 between clock edges → both rd_data go to 0 immediately. After release, reading a previously written address (e.g. 3) returns 3.

Source files
------------

// File: rtl/spm_dual_port.sv
// spm_dual_port: true dual-port scratchpad, 4096 x 32.
// The IF port serves instruction fetch and the MEM port serves load/store.
// Both ports are symmetric. Each has a registered read-data output with
// one-cycle latency.
// Reads are read-first: a read returns the array contents from before any
// write at the same edge.
// When both ports write one address at the same edge, the MEM-port data is
// kept.
// The array itself is never reset. Only the read-data registers clear
// asynchronously.

module spm_dual_port #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [ADDR_W-1:0] if_spm_addr,
  input  logic              if_spm_as_,
  input  logic              if_spm_rw,
  input  logic [DATA_W-1:0] if_spm_wr_data,
  input  logic [ADDR_W-1:0] mem_spm_addr,
  input  logic              mem_spm_as_,
  input  logic              mem_spm_rw,
  input  logic [DATA_W-1:0] mem_spm_wr_data,
  output logic [DATA_W-1:0] if_spm_rd_data,
  output logic [DATA_W-1:0] mem_spm_rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              if_rd_en;
  logic              if_wr_en;
  logic              mem_rd_en;
  logic              mem_wr_en;
  logic              if_wr_lost;
  logic [DATA_W-1:0] if_rd_q;
  logic [DATA_W-1:0] if_rd_d;
  logic [DATA_W-1:0] mem_rd_q;
  logic [DATA_W-1:0] mem_rd_d;

  // The strobe gates everything. An idle port with X on rw still decodes to
  // no access.
  assign if_rd_en   = ~if_spm_as_  &  if_spm_rw;
  assign if_wr_en   = ~if_spm_as_  & ~if_spm_rw;
  assign mem_rd_en  = ~mem_spm_as_ &  mem_spm_rw;
  assign mem_wr_en  = ~mem_spm_as_ & ~mem_spm_rw;

  // The IF write is dropped when the MEM port writes the same word.
  assign if_wr_lost = if_wr_en & mem_wr_en & (if_spm_addr == mem_spm_addr);

  // Array write ports. No writes are accepted while reset is held.
  always_ff @(posedge clk) begin
    if (rst_) begin
      if (if_wr_en && !if_wr_lost) begin
        mem_q[if_spm_addr] <= if_spm_wr_data;
      end
      if (mem_wr_en) begin
        mem_q[mem_spm_addr] <= mem_spm_wr_data;
      end
    end
  end

  // Read-data next state: capture the addressed word on a read, hold otherwise.
  always_comb begin
    if_rd_d  = if_rd_q;
    mem_rd_d = mem_rd_q;
    if (if_rd_en) begin
      if_rd_d = mem_q[if_spm_addr];
    end
    if (mem_rd_en) begin
      mem_rd_d = mem_q[mem_spm_addr];
    end
  end

  // Read-data registers. They clear asynchronously and stay 0 until the
  // first read.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      if_rd_q  <= '0;
      mem_rd_q <= '0;
    end else begin
      if_rd_q  <= if_rd_d;
      mem_rd_q <= mem_rd_d;
    end
  end

  assign if_spm_rd_data  = if_rd_q;
  assign mem_spm_rd_data = mem_rd_q;

endmodule

// File: tb/tb_spm_dual_port.sv
// Directed and random checks of spm_dual_port against a word-array model
// held in the bench.
module tb_spm_dual_port;

  logic        clk = 1'b0;
  logic        rst_;
  logic [11:0] if_spm_addr;
  logic        if_spm_as_;
  logic        if_spm_rw;
  logic [31:0] if_spm_wr_data;
  logic [11:0] mem_spm_addr;
  logic        mem_spm_as_;
  logic        mem_spm_rw;
  logic [31:0] mem_spm_wr_data;
  logic [31:0] if_spm_rd_data;
  logic [31:0] mem_spm_rd_data;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ref_mem [4096];
  bit          written [4096];
  logic [31:0] exp_if;
  logic [31:0] exp_mem;
  bit          kn_if;
  bit          kn_mem;

  spm_dual_port dut (
    .clk             (clk),
    .rst_            (rst_),
    .if_spm_addr     (if_spm_addr),
    .if_spm_as_      (if_spm_as_),
    .if_spm_rw       (if_spm_rw),
    .if_spm_wr_data  (if_spm_wr_data),
    .mem_spm_addr    (mem_spm_addr),
    .mem_spm_as_     (mem_spm_as_),
    .mem_spm_rw      (mem_spm_rw),
    .mem_spm_wr_data (mem_spm_wr_data),
    .if_spm_rd_data  (if_spm_rd_data),
    .mem_spm_rd_data (mem_spm_rd_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of activity on both ports. The model reads first and then
  // applies the writes, with the MEM write applied last so that it wins
  // on a collision.
  task automatic step(input string tag,
                      input bit ia, input bit irw, input logic [11:0] iad, input logic [31:0] iwd,
                      input bit ma, input bit mrw, input logic [11:0] mad, input logic [31:0] mwd);
    if_spm_as_      = ia;
    if_spm_rw       = irw;
    if_spm_addr     = iad;
    if_spm_wr_data  = iwd;
    mem_spm_as_     = ma;
    mem_spm_rw      = mrw;
    mem_spm_addr    = mad;
    mem_spm_wr_data = mwd;
    if (!ia && irw) begin
      kn_if  = written[iad];
      exp_if = ref_mem[iad];
    end
    if (!ma && mrw) begin
      kn_mem  = written[mad];
      exp_mem = ref_mem[mad];
    end
    if (!ia && !irw) begin
      ref_mem[iad] = iwd;
      written[iad] = 1'b1;
    end
    if (!ma && !mrw) begin
      ref_mem[mad] = mwd;
      written[mad] = 1'b1;
    end
    @(posedge clk);
    #1;
    if (kn_if)  check({tag, "/if"},  if_spm_rd_data,  exp_if);
    if (kn_mem) check({tag, "/mem"}, mem_spm_rd_data, exp_mem);
    @(negedge clk);
  endtask

  function automatic logic [11:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 12'($urandom_range(4090, 4095));
    return 12'($urandom_range(40, 103));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ = 1'b0;
    if_spm_as_ = 1'b1;  if_spm_rw = 1'b1;  if_spm_addr = '0;  if_spm_wr_data = '0;
    mem_spm_as_ = 1'b1; mem_spm_rw = 1'b1; mem_spm_addr = '0; mem_spm_wr_data = '0;
    #2;
    check("reset/if",  if_spm_rd_data,  32'h0);
    check("reset/mem", mem_spm_rd_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    exp_if = '0; exp_mem = '0; kn_if = 1'b1; kn_mem = 1'b1;

    // Fill words 0..39 via the MEM port with the IF port idle.
    for (int i = 0; i < 40; i++)
      step("fill", 1'b1, 1'b1, 12'h0, 32'h0, 1'b0, 1'b0, 12'(i), 32'(i));
    for (int i = 0; i < 40; i++)
      step("rd_mem", 1'b1, 1'b0, 12'hx, 32'hx, 1'b0, 1'b1, 12'(i), 32'h0);

    // IF readback with a concurrent MEM read.
    step("if_rd5",  1'b0, 1'b1, 12'd5,  32'h0, 1'b0, 1'b1, 12'd7, 32'h0);
    step("if_rd39", 1'b0, 1'b1, 12'd39, 32'h0, 1'b1, 1'b1, 12'd0, 32'h0);
    step("if_rd0",  1'b0, 1'b1, 12'd0,  32'h0, 1'b1, 1'b1, 12'd0, 32'h0);
    check("plan/if0", if_spm_rd_data, 32'd0);

    // Write collision: the MEM-port data must be the value stored.
    step("coll_wr", 1'b0, 1'b0, 12'd100, 32'hAAAA_AAAA, 1'b0, 1'b0, 12'd100, 32'h5555_5555);
    step("coll_rd", 1'b0, 1'b1, 12'd100, 32'h0,         1'b0, 1'b1, 12'd100, 32'h0);
    check("plan/coll", mem_spm_rd_data, 32'h5555_5555);

    // Read-during-write returns the old value, then idle/writes hold rd_data.
    step("rdw_init", 1'b1, 1'b1, 12'd0,   32'h0, 1'b0, 1'b0, 12'd200, 32'h0000_1234);
    step("rdw",      1'b0, 1'b1, 12'd200, 32'h0, 1'b0, 1'b0, 12'd200, 32'h0000_BEEF);
    check("plan/rdw_old", if_spm_rd_data, 32'h0000_1234);
    for (int k = 0; k < 5; k++)
      step("hold", 1'b1, 1'b0, 12'hx, 32'hx, 1'b0, 1'b0, 12'(300 + k), 32'(k));
    check("plan/hold", if_spm_rd_data, 32'h0000_1234);
    step("rdw_new", 1'b0, 1'b1, 12'd200, 32'h0, 1'b0, 1'b1, 12'd200, 32'h0);
    check("plan/rdw_new", if_spm_rd_data, 32'h0000_BEEF);

    // Random traffic over a small pool of addresses so that collisions and
    // read-during-write cases occur often.
    for (int n = 0; n < 400; n++) begin
      bit          ia, irw, ma, mrw;
      logic [11:0] iad, mad;
      ia  = ($urandom_range(0, 3) == 0);
      ma  = ($urandom_range(0, 3) == 0);
      irw = 1'($urandom_range(0, 1));
      mrw = 1'($urandom_range(0, 1));
      iad = rnd_addr();
      mad = ($urandom_range(0, 3) == 0) ? iad : rnd_addr();
      if (!ia && irw && !written[iad]) irw = 1'b0;
      if (!ma && mrw && !written[mad]) mrw = 1'b0;
      step("rand", ia, irw, iad, 32'($urandom), ma, mrw, mad, 32'($urandom));
    end

    // Reset in the middle of a read stream, asserted between clock edges.
    step("pre_rst", 1'b0, 1'b1, 12'd10, 32'h0, 1'b0, 1'b1, 12'd11, 32'h0);
    if_spm_addr = 12'd12;
    mem_spm_addr = 12'd13;
    @(posedge clk);
    #2;
    rst_ = 1'b0;
    #1;
    check("rst_mid/if",  if_spm_rd_data,  32'h0);
    check("rst_mid/mem", mem_spm_rd_data, 32'h0);
    if_spm_as_ = 1'b1;
    mem_spm_as_ = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b1;
    exp_if = '0; exp_mem = '0; kn_if = 1'b1; kn_mem = 1'b1;
    step("post_rst_idle", 1'b1, 1'b1, 12'd0, 32'h0, 1'b1, 1'b1, 12'd0, 32'h0);
    step("post_rst_rd3",  1'b0, 1'b1, 12'd3, 32'h0, 1'b0, 1'b1, 12'd3, 32'h0);
    check("plan/rst_rd3", mem_spm_rd_data, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
